// File: rtl/svm_timing_scheduler.sv
// rtl/svm_timing_scheduler.sv - SVM sampling tick, setpoint shadow register, clipping and atomic commit
module svm_timing_scheduler #(
    parameter int F_CLK       = 100000000,
    parameter int F_TAST      = 5000,
    parameter int TAST_PERIOD = F_CLK / F_TAST,
    parameter int W           = 15,
    parameter int T_ZERO_MIN  = 100
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         ENABLE,
    input  logic         SET_VALID,
    output logic         SET_READY,
    input  logic [W-1:0] SET_T1,
    input  logic [W-1:0] SET_T2,
    input  logic [2:0]   SET_SECTOR,
    output logic         TAST_STROBE,
    output logic [W-1:0] T_1,
    output logic [W-1:0] T_2,
    output logic [2:0]   SECTOR,
    output logic         ACTIVE,
    output logic         SAT,
    output logic         ERR_SECTOR
);

    localparam logic [W-1:0] LAST  = W'(TAST_PERIOD - 1);
    localparam logic [W-1:0] T_MAX = W'(TAST_PERIOD - T_ZERO_MIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         pending;
    logic [W-1:0] sh_t1;
    logic [W-1:0] sh_t2;
    logic [2:0]   sh_sector;

    logic         xfer;
    logic         legal;
    logic         boundary;
    logic         commit;
    logic [W:0]   sum;
    logic [W-1:0] clip_t1;
    logic [W-1:0] clip_t2;
    logic         clip_sat;

    // The shadow register is free whenever nothing is waiting for a boundary
    assign SET_READY = RST_N && !pending;
    assign xfer      = SET_VALID && SET_READY;
    assign legal     = (SET_SECTOR <= 3'd5);
    assign boundary  = ENABLE && (cnt == LAST);
    // Uses the pending flag from before this cycle, so a transfer landing in
    // the boundary cycle itself waits for the next boundary
    assign commit    = boundary && pending && ((state == S_ARMED) || (state == S_RUN));
    assign ACTIVE    = (state == S_RUN);

    // Next counter value; strobe is registered from it so it lines up with cnt
    always_comb begin
        cnt_nxt = '0;
        if (ENABLE) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Sampling counter and boundary strobe
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt         <= '0;
            TAST_STROBE <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            TAST_STROBE <= (cnt_nxt == LAST);
        end
    end

    // Shadow register capture, pending flag and illegal-sector pulse
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending    <= 1'b0;
            sh_t1      <= '0;
            sh_t2      <= '0;
            sh_sector  <= '0;
            ERR_SECTOR <= 1'b0;
        end else begin
            ERR_SECTOR <= xfer && !legal;
            if (xfer && legal) begin
                pending   <= 1'b1;
                sh_t1     <= SET_T1;
                sh_t2     <= SET_T2;
                sh_sector <= SET_SECTOR;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Clip so at least T_ZERO_MIN clocks of zero vector remain; T1 wins
    always_comb begin
        sum      = {1'b0, sh_t1} + {1'b0, sh_t2};
        clip_t1  = sh_t1;
        clip_t2  = sh_t2;
        clip_sat = 1'b0;
        if (sh_t1 >= T_MAX) begin
            clip_t1  = T_MAX;
            clip_t2  = '0;
            clip_sat = 1'b1;
        end else if (sum > {1'b0, T_MAX}) begin
            clip_t2  = T_MAX - sh_t1;
            clip_sat = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; dropping ENABLE returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ENABLE) state_nxt = S_ARMED;
            S_ARMED: if (commit) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
        if (!ENABLE) begin
            state_nxt = S_IDLE;
        end
    end

    // Committed outputs: load at commit, zero the times when disabled
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            T_1    <= '0;
            T_2    <= '0;
            SECTOR <= '0;
            SAT    <= 1'b0;
        end else if (!ENABLE) begin
            T_1 <= '0;
            T_2 <= '0;
            SAT <= 1'b0;
        end else if (commit) begin
            T_1    <= clip_t1;
            T_2    <= clip_t2;
            SECTOR <= sh_sector;
            SAT    <= clip_sat;
        end
    end

endmodule

// File: tb/tb_svm_timing_scheduler.sv
// tb/tb_svm_timing_scheduler.sv - directed self-checking bench for svm_timing_scheduler
module tb_svm_timing_scheduler;

    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         set_valid;
    logic         set_ready;
    logic [W-1:0] set_t1;
    logic [W-1:0] set_t2;
    logic [2:0]   set_sector;
    logic         tast_strobe;
    logic [W-1:0] t_1;
    logic [W-1:0] t_2;
    logic [2:0]   sector;
    logic         active;
    logic         sat;
    logic         err_sector;

    int n_checks = 0;
    int n_pass   = 0;
    int edges;
    int strobes;

    // 2000-clock period (T_MAX = 1900) keeps the run short
    svm_timing_scheduler #(
        .F_CLK      (10000000),
        .F_TAST     (5000),
        .W          (W),
        .T_ZERO_MIN (100)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ENABLE      (enable),
        .SET_VALID   (set_valid),
        .SET_READY   (set_ready),
        .SET_T1      (set_t1),
        .SET_T2      (set_t2),
        .SET_SECTOR  (set_sector),
        .TAST_STROBE (tast_strobe),
        .T_1         (t_1),
        .T_2         (t_2),
        .SECTOR      (sector),
        .ACTIVE      (active),
        .SAT         (sat),
        .ERR_SECTOR  (err_sector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the strobe is seen; returns edges taken, -1 on timeout
    task automatic wait_strobe(output int n);
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk);
            #1;
            if (tast_strobe) begin
                n = i;
                break;
            end
        end
        if (n < 0) check("strobe_timeout", 0, 1);
    endtask

    task automatic drive(input int t1, input int t2, input int sec);
        set_valid  = 1'b1;
        set_t1     = W'(t1);
        set_t2     = W'(t2);
        set_sector = 3'(sec);
    endtask

    // Write, let it commit at the next boundary, check the committed values
    task automatic write_commit(input string tag, input int t1, input int t2, input int sec,
                                input int e1, input int e2, input int esat);
        int n;
        drive(t1, t2, sec);
        step(1);
        set_valid = 1'b0;
        wait_strobe(n);
        step(1);
        check({tag, "_t1"}, t_1, e1);
        check({tag, "_t2"}, t_2, e2);
        check({tag, "_sec"}, sector, sec);
        check({tag, "_sat"}, sat, esat);
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        set_valid  = 1'b0;
        set_t1     = '0;
        set_t2     = '0;
        set_sector = '0;
        step(3);
        check("rst_ready", set_ready, 0);
        check("rst_t1", t_1, 0);
        check("rst_t2", t_2, 0);
        check("rst_sector", sector, 0);
        check("rst_active", active, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err_sector, 0);
        check("rst_strobe", tast_strobe, 0);

        rst_n = 1'b1;
        step(1);
        check("idle_ready", set_ready, 1);
        strobes = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (tast_strobe) strobes++;
        end
        check("disabled_no_strobe", strobes, 0);

        // Free-running tick with no setpoint
        enable = 1'b1;
        wait_strobe(edges);
        check("first_strobe_edges", edges, 1999);
        step(1);
        check("strobe_one_cycle", tast_strobe, 0);
        wait_strobe(edges);
        check("strobe_period", edges, 1999);
        check("armed_t1", t_1, 0);
        check("armed_t2", t_2, 0);
        check("armed_active", active, 0);

        // Write at count 100
        step(101);
        drive(500, 300, 2);
        check("ready_before_write", set_ready, 1);
        step(1);
        set_valid = 1'b0;
        check("ready_after_write", set_ready, 0);
        wait_strobe(edges);
        check("commit_strobe_edges", edges, 1898);
        check("pre_commit_t1", t_1, 0);
        step(1);
        check("c1_t1", t_1, 500);
        check("c1_t2", t_2, 300);
        check("c1_sec", sector, 2);
        check("c1_active", active, 1);
        check("c1_sat", sat, 0);
        check("c1_ready", set_ready, 1);

        // Clipping cases, T_MAX = 1900
        write_commit("clip_sum", 1200, 900, 1, 1200, 700, 1);
        write_commit("clip_t1", 2000, 50, 3, 1900, 0, 1);
        write_commit("t1_eq_max", 1900, 5, 4, 1900, 0, 1);
        write_commit("sum_eq_max", 1000, 900, 5, 1000, 900, 0);
        write_commit("sum_over1", 1899, 5, 0, 1899, 1, 1);

        // Transfer inside the boundary cycle waits a full period
        wait_strobe(edges);
        drive(1000, 200, 1);
        step(1);
        set_valid = 1'b0;
        check("bnd_held_t1", t_1, 1899);
        check("bnd_pending", set_ready, 0);
        step(1000);
        check("bnd_mid_t1", t_1, 1899);
        wait_strobe(edges);
        check("bnd_strobe_t1", t_1, 1899);
        step(1);
        check("bnd_t1", t_1, 1000);
        check("bnd_t2", t_2, 200);
        check("bnd_sat", sat, 0);
        check("bnd_sec", sector, 1);

        // Illegal sector is dropped
        drive(300, 100, 7);
        step(1);
        set_valid = 1'b0;
        check("err_pulse", err_sector, 1);
        check("err_ready", set_ready, 1);
        step(1);
        check("err_one_cycle", err_sector, 0);
        wait_strobe(edges);
        step(1);
        check("err_t1_held", t_1, 1000);
        check("err_sec_held", sector, 1);
        write_commit("after_err", 700, 600, 2, 700, 600, 0);

        // Disable mid-period keeps the pending value
        drive(400, 100, 3);
        step(1);
        set_valid = 1'b0;
        step(799);
        enable = 1'b0;
        step(1);
        check("dis_t1", t_1, 0);
        check("dis_t2", t_2, 0);
        check("dis_active", active, 0);
        check("dis_pending", set_ready, 0);
        step(20);
        enable = 1'b1;
        wait_strobe(edges);
        check("reen_strobe_edges", edges, 1999);
        check("reen_armed_t1", t_1, 0);
        step(1);
        check("reen_t1", t_1, 400);
        check("reen_t2", t_2, 100);
        check("reen_sec", sector, 3);
        check("reen_active", active, 1);

        // Reset mid-period discards the pending value
        drive(600, 50, 4);
        step(1);
        set_valid = 1'b0;
        step(500);
        rst_n = 1'b0;
        check("rst2_ready_low", set_ready, 0);
        step(1);
        check("rst2_t1", t_1, 0);
        check("rst2_sec", sector, 0);
        check("rst2_active", active, 0);
        rst_n = 1'b1;
        step(1);
        check("rst2_ready", set_ready, 1);
        wait_strobe(edges);
        step(1);
        check("rst2_no_commit_t1", t_1, 0);
        check("rst2_no_commit_active", active, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/svm_timing_scheduler.md
Name: svm_timing_scheduler

Overview:
- Feeds the space-vector PWM timing stage with per-sample active-vector times (T_1, T_2) and the sector number.
- Generates the sampling tick and accepts setpoints from the control loop through a valid/ready shadow register.
- Clips the setpoint so a minimum zero-vector time remains, then commits it atomically at the sampling boundary.
- Sits between the current/angle controller and the vector PWM generator.

Parameters:
F_CLK, 100000000, system clock frequency in Hz
F_TAST, 5000, sampling frequency in Hz
TAST_PERIOD, F_CLK/F_TAST (20000), clocks per sampling period; must be <= 2^W-1
W, 15, width of the timing values
T_ZERO_MIN, 100, minimum zero-vector clocks per period

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, synchronous, active-low
ENABLE  in  1  run request
SET_VALID  in  1  setpoint valid
SET_READY  out  1  shadow register free
SET_T1  in  W  requested first active-vector time, clocks
SET_T2  in  W  requested second active-vector time, clocks
SET_SECTOR  in  3  requested sector, legal 0..5
TAST_STROBE  out  1  one-cycle pulse on the last clock of each sampling period
T_1  out  W  committed first active time
T_2  out  W  committed second active time
SECTOR  out  3  committed sector
ACTIVE  out  1  high in RUN state
SAT  out  1  committed value was clipped this period
ERR_SECTOR  out  1  one-cycle pulse on an illegal sector write

Behaviour:
- Interface: one clock, CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N low at a CLK edge):
  - Counter = 0, pending = 0, state = IDLE.
  - T_1, T_2, SECTOR, ACTIVE, SAT, ERR_SECTOR, TAST_STROBE = 0.
  - SET_READY = 0 while RST_N is low.
  - Reset mid-period discards the shadow register and committed values.
- Counter:
  - Runs 0..TAST_PERIOD-1 and wraps while ENABLE = 1.
  - TAST_STROBE is registered and is high exactly in the cycle the counter equals TAST_PERIOD-1 (the boundary cycle).
  - With ENABLE = 0, the counter is held at 0 and no strobe is produced.
- Handshake:
  - SET_READY = !pending, outside reset.
  - Transfer occurs on SET_VALID & SET_READY.
  - Legal sector: capture SET_T1, SET_T2 and SET_SECTOR into the shadow register; pending = 1, so SET_READY falls the next cycle.
  - Sector 6 or 7: the transfer completes but the data is dropped. ERR_SECTOR pulses the next cycle and pending is unchanged.
- Commit:
  - Happens in the boundary cycle when pending = 1 and state is ARMED or RUN.
  - Outputs update on the following edge (latency 1 from the strobe), and pending clears.
  - With no pending value, outputs hold and SAT holds.
  - A transfer in the boundary cycle itself is not committed; it waits for the next boundary.
- Clipping:
  - T_MAX = TAST_PERIOD - T_ZERO_MIN (19900). The sum is computed in W+1 bits.
  - If SET_T1 >= T_MAX: T_1 = T_MAX, T_2 = 0, SAT = 1.
  - Else if T1+T2 > T_MAX: T_1 = T1, T_2 = T_MAX - T1, SAT = 1.
  - Otherwise values pass unchanged and SAT = 0. T1 has priority.
- FSM:
  - IDLE: ENABLE = 0.
  - IDLE -> ARMED when ENABLE = 1.
  - ARMED -> RUN at the first commit.
  - Any state -> IDLE when ENABLE = 0; on the next edge T_1, T_2, SAT and ACTIVE go to 0 and the counter goes to 0. Pending is retained.
  - ACTIVE = 1 only in RUN.
  - In ARMED, T_1 and T_2 are 0.
  - Handshakes are accepted in all states outside reset.

Test Plan:
- Reset, then ENABLE = 1 with no write -> TAST_STROBE every 20000 cycles, T_1 = T_2 = 0, ACTIVE = 0.
- Write T1 = 5000, T2 = 3000, sector 2 at count 100 -> SET_READY low from count 101. Cycle after the strobe: T_1 = 5000, T_2 = 3000, SECTOR = 2, ACTIVE = 1, SAT = 0, SET_READY = 1.
- Write T1 = 12000, T2 = 9000 -> committed 12000/7900, SAT = 1. Then T1 = 20000, T2 = 50 -> 19900/0, SAT = 1.
- SET_VALID held high during the boundary cycle with T1 = 1000 -> accepted, not committed. Committed one cycle after the next strobe; prior values held for a full period.
- Write sector 7 -> ERR_SECTOR pulses once, SET_READY stays 1, outputs unchanged. A following legal write commits normally.
- ENABLE low at count 8000 after a pending write -> T_1 = T_2 = 0, ACTIVE = 0 next cycle. Re-enable -> pending value commits at the first boundary. Repeat with RST_N low instead -> pending lost, outputs 0.
